// File: rtl/adc_array_ctrl.sv
// adc_array_ctrl: sequences init/type/conf/conv operations across NCH Intan
// channel controllers behind one level-based host handshake. It also produces
// a running averaged chip temperature.
//
// Optional feature macro: ADC_TIMEOUT_EN
//   defined   - per-operation timeout counter, err_timeout/err_mask reporting
//   undefined - RUN waits indefinitely, err_timeout/err_mask tied to 0
//
// Ports:
//   clk, rst                 clock, async active-low reset
//   fs_init..fs_conv         host start levels (in)
//   fd_init..fd_conv         host done levels (out)
//   ch_en[NCH]               channel enable mask, snapshotted per operation
//   fsc_init..fsc_conv[NCH]  per-channel start levels (out)
//   fdc_init..fdc_conv[NCH]  per-channel done levels (in)
//   chan_temp[NCH*TW]        channel i temperature at [i*TW +: TW]
//   device_temp[TW]          averaged temperature
//   err_timeout, err_mask    last operation timed out / channels not finished
module adc_array_ctrl #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned LNCH = 2,
  parameter int unsigned TW   = 16,
  parameter int unsigned TOUT = 1000000,
  parameter int unsigned CW   = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs_init,
  input  logic              fs_type,
  input  logic              fs_conf,
  input  logic              fs_conv,
  output logic              fd_init,
  output logic              fd_type,
  output logic              fd_conf,
  output logic              fd_conv,
  input  logic [NCH-1:0]    ch_en,
  output logic [NCH-1:0]    fsc_init,
  output logic [NCH-1:0]    fsc_type,
  output logic [NCH-1:0]    fsc_conf,
  output logic [NCH-1:0]    fsc_conv,
  input  logic [NCH-1:0]    fdc_init,
  input  logic [NCH-1:0]    fdc_type,
  input  logic [NCH-1:0]    fdc_conf,
  input  logic [NCH-1:0]    fdc_conv,
  input  logic [NCH*TW-1:0] chan_temp,
  output logic [TW-1:0]     device_temp,
  output logic              err_timeout,
  output logic [NCH-1:0]    err_mask
);

  localparam int unsigned AW = TW + LNCH;

  // Elaboration guard on the timeout parameters.
  if (TOUT < 2 || (64'(1) << CW) <= 64'(TOUT)) begin : g_bad_param
    $error("adc_array_ctrl: TOUT must be >= 2 and fit in CW bits");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state;
  logic [1:0]          op;
  logic [1:0]          op_sel;
  logic [NCH-1:0]      mask;
  logic [NCH-1:0]      done_seen;
  logic [NCH-1:0]      ds_next;
  logic                complete;
  logic                timeout;
  logic [3:0]          fs;
  logic [3:0]          fd;
  logic [3:0][NCH-1:0] fdc;
  logic [3:0][NCH-1:0] fsc;

  assign fs  = {fs_conv, fs_conf, fs_type, fs_init};
  assign fdc = {fdc_conv, fdc_conf, fdc_type, fdc_init};
  assign {fd_conv, fd_conf, fd_type, fd_init}     = fd;
  assign {fsc_conv, fsc_conf, fsc_type, fsc_init} = fsc;

  // Start priority init > type > conf > conv (last assignment wins).
  always_comb begin
    op_sel = 2'd3;
    if (fs[2]) op_sel = 2'd2;
    if (fs[1]) op_sel = 2'd1;
    if (fs[0]) op_sel = 2'd0;
  end

  // Completion includes the done bits arriving this cycle.
  assign ds_next  = done_seen | (fdc[op] & mask);
  assign complete = (ds_next == mask);

`ifdef ADC_TIMEOUT_EN
  logic [CW-1:0] cnt;

  assign timeout = (cnt == CW'(TOUT - 1));

  // Timeout counter and error report; cleared when a new operation starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_mask    <= '0;
    end else if (state == S_IDLE && |fs) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_mask    <= '0;
    end else if (state == S_RUN) begin
      cnt <= cnt + 1'b1;
      if (timeout && !complete) begin
        err_timeout <= 1'b1;
        err_mask    <= mask & ~ds_next;
      end
    end
  end
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
  assign err_mask    = '0;
`endif

  // Operation sequencer with registered start/done levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      op        <= 2'd0;
      mask      <= '0;
      done_seen <= '0;
      fsc       <= '0;
      fd        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|fs) begin
            op          <= op_sel;
            mask        <= ch_en;
            done_seen   <= '0;
            fsc[op_sel] <= ch_en;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          done_seen <= ds_next;
          if (complete || timeout) begin
            fsc     <= '0;
            fd[op]  <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!fs[op]) begin
            fd    <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Round-robin temperature average; disabled channels contribute the
  // current average so the result holds when nothing is enabled.
  logic [LNCH-1:0] idx;
  logic [AW-1:0]   acc;
  logic [TW-1:0]   term;
  logic [AW-1:0]   sum;

  assign term = ch_en[idx] ? chan_temp[idx*TW +: TW] : device_temp;
  assign sum  = acc + AW'(term);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx         <= '0;
      acc         <= '0;
      device_temp <= '0;
    end else begin
      idx <= idx + 1'b1;
      if (idx == LNCH'(NCH - 1)) begin
        device_temp <= TW'(sum >> LNCH);
        acc         <= '0;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule

// File: doc/adc_array_ctrl.md
Name: adc_array_ctrl

Overview:
- Parametrised successor to the fixed four-chip ADC wrapper: sequences the init/type/conf/conv operations across NCH Intan channels behind one host-side level handshake.
- Adds a per-channel enable mask snapshotted per operation, and latching of per-channel done flags that arrive at different times.
- Adds a per-operation timeout with failing-channel report, and a sequential averaged chip temperature.
- Sits between the host control FSM and the array of per-chip Intan controllers.

Parameters:
- NCH, 4, channel count; power of two, 2..16.
- LNCH, 2, log2(NCH).
- TW, 16, per-channel temperature width.
- TOUT, 1000000, timeout in clk cycles per operation (>=2).
- CW, 20, timeout counter width; must satisfy 2^CW > TOUT.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- fs_init, fs_type, fs_conf, fs_conv  input  1 each  host start levels
- fd_init, fd_type, fd_conf, fd_conv  output  1 each  host done levels
- ch_en  input  NCH  channel enable mask
- fsc_init, fsc_type, fsc_conf, fsc_conv  output  NCH each  per-channel start levels
- fdc_init, fdc_type, fdc_conf, fdc_conv  input  NCH each  per-channel done levels
- chan_temp  input  NCH*TW  channel i temperature at bits [i*TW +: TW]
- device_temp  output  TW  averaged temperature
- err_timeout  output  1  last operation timed out
- err_mask  output  NCH  channels that did not finish the last operation

Behaviour:
- Reset (rst=0, async) values:
  - all fd_* = 0, all fsc_* = 0
  - device_temp = 0, err_timeout = 0, err_mask = 0
  - FSM = IDLE; internal op, mask, done_seen and counter = 0
- Handshake, both sides level-based: a start is held until its done is seen high; done is held until start drops.
- IDLE:
  - On any fs_* = 1, latch op with priority init > type > conf > conv.
  - Snapshot mask = ch_en, clear done_seen and counter, clear err_timeout/err_mask, go to RUN.
  - Latency: fsc_op = mask is visible the cycle after fs is sampled.
- RUN:
  - fsc_op = mask; all other fsc_* = 0.
  - Each cycle: done_seen |= fdc_op & mask; counter increments.
  - Complete when done_seen (including this cycle's bits) == mask -> go to DONE next cycle.
  - mask == 0 counts as complete on the first RUN cycle.
  - Changes to ch_en during RUN are ignored.
- Timeout:
  - Triggers when counter == TOUT-1 and the operation is not complete.
  - Sets err_timeout = 1 and err_mask = mask & ~done_seen, then goes to DONE.
  - If completion and timeout occur in the same cycle, completion wins and err_timeout stays 0.
- DONE:
  - All fsc_* = 0; fd_op = 1.
  - When fs_op = 0, drop fd_op and go to IDLE.
  - Other fs_* raised while busy are not acted on until IDLE; they are then sampled normally.
  - err flags persist until the next operation starts.
- Temperature, runs continuously and independent of the FSM:
  - An index 0..NCH-1 advances every cycle.
  - Accumulator width is TW+LNCH.
  - Each cycle it adds chan_temp[idx] if ch_en[idx] = 1, otherwise the current device_temp.
  - At idx == NCH-1: device_temp <= (acc + term) >> LNCH; acc <= 0; idx wraps to 0.
  - All channels disabled: device_temp holds its value.
- Reset mid-operation aborts immediately to the reset values above.

Optional Feature:
- ADC_TIMEOUT_EN
  - Defined: timeout counter and err_timeout/err_mask behave as described.
  - Undefined: no counter is built, RUN waits indefinitely for completion, and err_timeout/err_mask are tied to 0.

Test Plan:
- NCH=4, ch_en=1111, pulse fs_init high; channels raise fdc_init at cycles 3, 7, 5, 9 -> fsc_init=1111 from cycle 1, fd_init=1 only after the cycle-9 bit, fsc_init=0000, err_timeout=0.
- ch_en=0101, fs_conf; only bits 0 and 2 raise fdc_conf -> fd_conf asserts; fsc_conf bits 1 and 3 never go high.
- ADC_TIMEOUT_EN defined, TOUT=50, ch_en=1111, channel 2 never answers fs_conv -> fd_conv after 50 RUN cycles, err_timeout=1, err_mask=0100.
- fs_type and fs_conv raised in the same cycle -> type runs first; conv starts only after fd_type drops and the FSM returns to IDLE.
- ch_en=1111, temps 100/200/300/400 -> device_temp=250 within 2*NCH cycles; then ch_en=0011 with temps 100/200 -> device_temp converges toward 150.
- rst driven low during RUN -> fsc_*, fd_* and err outputs go to 0 immediately; after rst releases, a new fs_init completes normally.
